eth_encode_blk: RTL and testbench

ETH_ENCODE_BLK -- requirements
Module: eth_encode

---
 rtl/eth_pkg.sv | 20 ++
 rtl/eth_encode_blk.sv | 102 ++++++++++
 tb/tb_eth_encode_blk.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: shared state type, frame constants and header byte-ordering helper for the Ethernet encoder
package eth_pkg;

    typedef enum logic [1:0] {IDLE, DATA, CTL} state_t;

    localparam int          FRAME_LEN   = 60;
    localparam int          FRAME_WORDS = 8;
    localparam logic [47:0] DEF_MAC     = 48'h0010a47bea80;
    localparam logic [15:0] DEF_TYPE    = 16'h0800;
    localparam logic [47:0] DEF_DST_MAC = 48'hffffffffffff;

    // Byte-reverses a 24-byte big-endian header so frame byte 0 lands in bits [7:0]
    function automatic logic [191:0] hdr_le(input logic [191:0] be);
        logic [191:0] le;
        le = '0;
        for (int k = 0; k < 24; k++) le[8*k +: 8] = be[191-8*k -: 8];
        return le;
    endfunction

endpackage

// File: rtl/eth_encode_blk.sv
// eth_encode_blk: wraps each 64-bit ack/ps2 message into a 60-byte Ethernet frame plus a length word
module eth_encode_blk
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC     = DEF_MAC,
    parameter logic [15:0] TYPE    = DEF_TYPE,
    parameter logic [47:0] DST_MAC = DEF_DST_MAC
)(
    input  logic        clk,
    input  logic        rst,
    output logic        ack_rd_en_out,
    input  logic [63:0] ack_rd_d_in,
    input  logic        ack_rd_empty_in,
    output logic        ps2_rd_en_out,
    input  logic [63:0] ps2_rd_d_in,
    input  logic        ps2_rd_empty_in,
    output logic        data_wr_en_out,
    output logic [63:0] data_wr_d_out,
    input  logic        data_wr_full_in,
    output logic        ctl_wr_en_out,
    output logic [15:0] ctl_wr_d_out,
    input  logic        ctl_wr_full_in
);

    state_t       r_state, w_state_nxt;
    logic [2:0]   r_idx, w_idx_nxt;
    logic [63:0]  r_msg, w_msg_nxt;
    logic         r_ack_rd_en, r_ps2_rd_en;
    logic         w_ack_pop, w_ps2_pop;
    logic [191:0] w_hdr;
    logic [63:0]  w_word;

    assign w_hdr = hdr_le({DST_MAC, MAC, TYPE, r_msg, 16'h0000});

    // Word mux: the first three words carry header and message, the rest are zero padding
    always_comb begin
        w_word = '0;
        case (r_idx)
            3'd0:    w_word = w_hdr[63:0];
            3'd1:    w_word = w_hdr[127:64];
            3'd2:    w_word = w_hdr[191:128];
            default: w_word = '0;
        endcase
    end

    // State, word index, latched message and registered one-cycle pop pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_msg       <= '0;
            r_ack_rd_en <= 1'b0;
            r_ps2_rd_en <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_msg       <= w_msg_nxt;
            r_ack_rd_en <= w_ack_pop;
            r_ps2_rd_en <= w_ps2_pop;
        end
    end

    // Next-state logic: ack beats ps2 in IDLE, writes stall on full without advancing
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_msg_nxt      = r_msg;
        w_ack_pop      = 1'b0;
        w_ps2_pop      = 1'b0;
        data_wr_en_out = 1'b0;
        ctl_wr_en_out  = 1'b0;
        case (r_state)
            IDLE: begin
                w_ack_pop = !ack_rd_empty_in;
                w_ps2_pop = ack_rd_empty_in && !ps2_rd_empty_in;
                if (w_ack_pop || w_ps2_pop) begin
                    w_msg_nxt   = w_ack_pop ? ack_rd_d_in : ps2_rd_d_in;
                    w_idx_nxt   = '0;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                data_wr_en_out = !data_wr_full_in;
                if (data_wr_en_out) begin
                    w_idx_nxt = r_idx + 3'd1;
                    if (r_idx == 3'(FRAME_WORDS - 1)) w_state_nxt = CTL;
                end
            end
            CTL: begin
                ctl_wr_en_out = !ctl_wr_full_in;
                if (ctl_wr_en_out) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign data_wr_d_out = (r_state == DATA) ? w_word : '0;
    assign ctl_wr_d_out  = (r_state == CTL) ? 16'(FRAME_LEN) : '0;
    assign ack_rd_en_out = r_ack_rd_en;
    assign ps2_rd_en_out = r_ps2_rd_en;

endmodule

// File: tb/tb_eth_encode_blk.sv
// tb_eth_encode_blk: scoreboard bench for the Ethernet frame encoder
module tb_eth_encode_blk;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ack_rd_en_out, ps2_rd_en_out, data_wr_en_out, ctl_wr_en_out;
    logic [63:0] ack_rd_d_in = '0, ps2_rd_d_in = '0, data_wr_d_out;
    logic        ack_rd_empty_in = 1'b1, ps2_rd_empty_in = 1'b1;
    logic        data_wr_full_in = 1'b0, ctl_wr_full_in = 1'b0;
    logic [15:0] ctl_wr_d_out;

    typedef struct {bit is_ctl; logic [63:0] v;} ev_t;

    int          tests = 0, fails = 0, cyc = 0;
    int          wr_cnt = 0, ctl_cnt = 0, pop_cnt = 0, ps2_pop_cyc = 0;
    ev_t         expq[$];
    bit          popq[$];
    logic [63:0] ackq[$], ps2q[$];
    int          ctl_cyc[$];
    bit          pa, pp;

    eth_encode_blk dut (
        .clk(clk), .rst(rst),
        .ack_rd_en_out(ack_rd_en_out), .ack_rd_d_in(ack_rd_d_in), .ack_rd_empty_in(ack_rd_empty_in),
        .ps2_rd_en_out(ps2_rd_en_out), .ps2_rd_d_in(ps2_rd_d_in), .ps2_rd_empty_in(ps2_rd_empty_in),
        .data_wr_en_out(data_wr_en_out), .data_wr_d_out(data_wr_d_out), .data_wr_full_in(data_wr_full_in),
        .ctl_wr_en_out(ctl_wr_en_out), .ctl_wr_d_out(ctl_wr_d_out), .ctl_wr_full_in(ctl_wr_full_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] model_word(input logic [63:0] msg, input int i);
        logic [7:0]  b [0:63];
        logic [47:0] dst, src;
        logic [15:0] typ;
        logic [63:0] w;
        dst = 48'hffffffffffff;
        src = 48'h0010a47bea80;
        typ = 16'h0800;
        for (int k = 0; k < 64; k++) b[k] = 8'h00;
        for (int k = 0; k < 6; k++) begin
            b[k]     = dst[47-8*k -: 8];
            b[6 + k] = src[47-8*k -: 8];
        end
        b[12] = typ[15:8];
        b[13] = typ[7:0];
        for (int k = 0; k < 8; k++) b[14 + k] = msg[63-8*k -: 8];
        for (int k = 0; k < 8; k++) w[8*k +: 8] = b[8*i + k];
        return w;
    endfunction

    task automatic push_ev(input bit is_ctl, input logic [63:0] v);
        ev_t e;
        e.is_ctl = is_ctl;
        e.v = v;
        expq.push_back(e);
    endtask

    task automatic exp_frame(input logic [63:0] msg, input bit src);
        popq.push_back(src);
        for (int i = 0; i < 8; i++) push_ev(1'b0, model_word(msg, i));
        push_ev(1'b1, 64'd60);
    endtask

    task automatic sb(input bit is_ctl, input logic [63:0] v, input string nm);
        ev_t e;
        if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s_unexpected: got %h expected no write", nm, v);
        end else begin
            e = expq.pop_front();
            check({nm, "_kind"}, 64'(is_ctl), 64'(e.is_ctl));
            check(nm, v, e.v);
        end
    endtask

    task automatic pop_chk(input bit src);
        if (popq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL pop_unexpected: got src %0d expected no pop", src);
        end else check("pop_src", 64'(src), 64'(popq.pop_front()));
    endtask

    // Monitor: compares every write and pop against the scoreboard queues
    always @(negedge clk) begin
        if (rst) begin
            if (data_wr_en_out) begin
                wr_cnt++;
                sb(1'b0, data_wr_d_out, "data");
            end
            if (ctl_wr_en_out) begin
                ctl_cnt++;
                ctl_cyc.push_back(cyc);
                sb(1'b1, {48'h0, ctl_wr_d_out}, "ctl");
            end
            if (ack_rd_en_out) begin
                pop_cnt++;
                pop_chk(1'b0);
            end
            if (ps2_rd_en_out) begin
                pop_cnt++;
                ps2_pop_cyc = cyc;
                pop_chk(1'b1);
            end
        end
    end

    // First-word-fall-through FIFO models for the two sources
    always begin
        @(negedge clk);
        pa = ack_rd_en_out;
        pp = ps2_rd_en_out;
        @(posedge clk);
        #1;
        if (pa && ackq.size() > 0) void'(ackq.pop_front());
        if (pp && ps2q.size() > 0) void'(ps2q.pop_front());
        ack_rd_empty_in = (ackq.size() == 0);
        ack_rd_d_in     = (ackq.size() > 0) ? ackq[0] : 64'h0;
        ps2_rd_empty_in = (ps2q.size() == 0);
        ps2_rd_d_in     = (ps2q.size() > 0) ? ps2q[0] : 64'h0;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_wr(input int target, input string nm);
        int b = 0;
        while (wr_cnt < target && b < 300) begin
            tick();
            b++;
        end
        check({nm, "_wait_wr"}, 64'(wr_cnt >= target), 64'd1);
    endtask

    task automatic wait_ctl(input int target, input string nm);
        int b = 0;
        while (ctl_cnt < target && b < 300) begin
            tick();
            b++;
        end
        check({nm, "_wait_ctl"}, 64'(ctl_cnt >= target), 64'd1);
    endtask

    initial begin
        int base, c0, w0, p0;
        logic [63:0] m;
        tick(3);
        check("rst_ctrl", {44'h0, ack_rd_en_out, ps2_rd_en_out, data_wr_en_out, ctl_wr_en_out, ctl_wr_d_out}, 64'h0);
        check("rst_data", data_wr_d_out, 64'h0);
        rst = 1'b1;
        tick(5);
        check("idle_no_activity", 64'(wr_cnt + ctl_cnt + pop_cnt), 64'h0);

        popq.push_back(1'b0);
        push_ev(1'b0, 64'h1000ffffffffffff);
        push_ev(1'b0, 64'h2301000880ea7ba4);
        push_ev(1'b0, 64'h0000efcdab896745);
        for (int i = 0; i < 5; i++) push_ev(1'b0, 64'h0);
        push_ev(1'b1, 64'h003c);
        ackq.push_back(64'h0123456789abcdef);
        wait_ctl(1, "single");
        check("single_pops", 64'(pop_cnt), 64'd1);

        exp_frame(64'haaaa5555aaaa5555, 1'b0);
        exp_frame(64'h0f1e2d3c4b5a6978, 1'b1);
        ackq.push_back(64'haaaa5555aaaa5555);
        ps2q.push_back(64'h0f1e2d3c4b5a6978);
        wait_ctl(3, "prio");
        check("prio_order", 64'(ps2_pop_cyc > ctl_cyc[1]), 64'd1);

        m = 64'hdeadbeefcafef00d;
        exp_frame(m, 1'b0);
        base = wr_cnt;
        ackq.push_back(m);
        wait_wr(base + 3, "bp");
        data_wr_full_in = 1'b1;
        repeat (5) begin
            #1;
            check("bp_hold_data", data_wr_d_out, model_word(m, 3));
            check("bp_no_write", 64'(data_wr_en_out), 64'd0);
            tick();
        end
        data_wr_full_in = 1'b0;
        wait_wr(base + 8, "bp");
        ctl_wr_full_in = 1'b1;
        repeat (3) begin
            #1;
            check("bp_ctl_stall", 64'(ctl_wr_en_out), 64'd0);
            tick();
        end
        ctl_wr_full_in = 1'b0;
        wait_ctl(4, "bp");
        check("bp_words", 64'(wr_cnt - base), 64'd8);

        c0 = ctl_cnt;
        w0 = wr_cnt;
        p0 = pop_cnt;
        for (int k = 0; k < 4; k++) begin
            m = 64'h1111000000000000 * 64'(k + 1) + 64'(k);
            exp_frame(m, 1'b1);
            ps2q.push_back(m);
        end
        wait_ctl(c0 + 4, "tput");
        tick(2);
        check("tput_data", 64'(wr_cnt - w0), 64'd32);
        check("tput_pops", 64'(pop_cnt - p0), 64'd4);
        check("tput_ctl", 64'(ctl_cnt - c0), 64'd4);
        for (int k = 1; k < 4; k++) check("tput_spacing", 64'(ctl_cyc[c0 + k] - ctl_cyc[c0 + k - 1]), 64'd10);

        m = 64'h1122334455667788;
        popq.push_back(1'b0);
        for (int i = 0; i < 5; i++) push_ev(1'b0, model_word(m, i));
        base = wr_cnt;
        ackq.push_back(m);
        wait_wr(base + 5, "mid");
        rst = 1'b0;
        #1;
        check("mid_rst_outs", {44'h0, ack_rd_en_out, ps2_rd_en_out, data_wr_en_out, ctl_wr_en_out, ctl_wr_d_out}, 64'h0);
        c0 = ctl_cnt;
        tick(3);
        rst = 1'b1;
        tick(3);
        check("mid_no_ctl", 64'(ctl_cnt), 64'(c0));
        check("mid_drained", 64'(expq.size()), 64'd0);
        m = 64'h8877665544332211;
        exp_frame(m, 1'b1);
        ps2q.push_back(m);
        wait_ctl(c0 + 1, "mid");
        tick(3);
        check("end_exp_empty", 64'(expq.size()), 64'd0);
        check("end_pop_empty", 64'(popq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
